e603_boot_copier: RTL and testbench

//  Reader/initiator for the mask ROM: after reset release, copies a fixed boot image of
//  LEN words out of the combinational mask ROM into main RAM over an ICB master port.

---
 rtl/e603_boot_copier_pkg.sv | 12 +
 rtl/e603_boot_copier.sv | 83 ++++++++
 tb/tb_e603_boot_copier.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/e603_boot_copier_pkg.sv
// e603_boot_copier_pkg: shared FSM state encoding and ICB constants for the boot copier
package e603_boot_copier_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CMD  = 3'd2,
    S_RSP  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;
  localparam logic ICB_CMD_WRITE = 1'b0;
endpackage

// File: rtl/e603_boot_copier.sv
// e603_boot_copier: copies LEN mask-ROM words into RAM over ICB, holding the core in reset until done
module e603_boot_copier
  import e603_boot_copier_pkg::*;
#(
  parameter int          AW       = 12,
  parameter int          DW       = 32,
  parameter int          SRC_WIDX = 0,
  parameter int          LEN      = 10,
  parameter logic [31:0] DST_BASE = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [AW-3:0]   rom_addr,
  input  logic [DW-1:0]   rom_dout,
  output logic            icb_cmd_valid,
  input  logic            icb_cmd_ready,
  output logic [31:0]     icb_cmd_addr,
  output logic            icb_cmd_read,
  output logic [DW-1:0]   icb_cmd_wdata,
  output logic [DW/8-1:0] icb_cmd_wmask,
  input  logic            icb_rsp_valid,
  output logic            icb_rsp_ready,
  input  logic            icb_rsp_err,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            core_hold
);
  localparam int IW = (LEN > 0) ? $clog2(LEN + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'((LEN > 0) ? LEN - 1 : 0);

  if (SRC_WIDX + LEN > 2 ** (AW - 2)) begin : g_range_chk
    $error("e603_boot_copier: SRC_WIDX+LEN exceeds ROM word space");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: state_d = start ? ((LEN > 0) ? S_READ : S_DONE) : S_IDLE;
      S_READ: begin
        wdata_d = rom_dout;
        state_d = S_CMD;
      end
      S_CMD:  state_d = icb_cmd_ready ? S_RSP : S_CMD;
      S_RSP: if (icb_rsp_valid) begin
        state_d = icb_rsp_err ? S_ERR : (idx_q == LAST) ? S_DONE : S_READ;
        idx_d   = (!icb_rsp_err && idx_q != LAST) ? idx_q + 1'b1 : idx_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign rom_addr      = (AW-2)'(SRC_WIDX) + (AW-2)'(idx_q);
  assign icb_cmd_valid = state_q == S_CMD;
  assign icb_cmd_addr  = DST_BASE + 32'({idx_q, 2'b00});
  assign icb_cmd_read  = ICB_CMD_WRITE;
  assign icb_cmd_wdata = wdata_q;
  assign icb_cmd_wmask = {(DW/8){1'b1}};
  assign icb_rsp_ready = state_q == S_RSP;
  assign busy          = state_q inside {S_READ, S_CMD, S_RSP};
  assign done          = state_q == S_DONE;
  assign err           = state_q == S_ERR;
  assign core_hold     = state_q != S_DONE;
endmodule

// File: tb/tb_e603_boot_copier.sv
// tb_e603_boot_copier: directed self-checking bench for the boot copier (LEN=10 and LEN=0 instances)
module tb_e603_boot_copier;
  logic        clk = 0;
  logic        rst = 1, start = 0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        cmd_valid, cmd_ready = 0, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid = 0, rsp_ready, rsp_err = 0;
  logic        busy, done, err, core_hold;

  logic        rst0 = 1, start0 = 0;
  logic [9:0]  rom_addr0;
  logic        cmd_valid0, cmd_read0, rsp_ready0, busy0, done0, err0, core_hold0;
  logic [31:0] cmd_addr0, cmd_wdata0;
  logic [3:0]  cmd_wmask0;
  logic        seen_cmd0 = 0;

  int errors = 0, checks = 0, ncmd = 0;

  always #5 clk = ~clk;

  assign rom_dout = 32'hB007_0000 + {22'd0, rom_addr} * 32'd3;

  e603_boot_copier dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
    .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(rsp_err),
    .busy(busy), .done(done), .err(err), .core_hold(core_hold)
  );

  e603_boot_copier #(.LEN(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .rom_addr(rom_addr0), .rom_dout(32'h1234_5678),
    .icb_cmd_valid(cmd_valid0), .icb_cmd_ready(1'b1), .icb_cmd_addr(cmd_addr0),
    .icb_cmd_read(cmd_read0), .icb_cmd_wdata(cmd_wdata0), .icb_cmd_wmask(cmd_wmask0),
    .icb_rsp_valid(1'b1), .icb_rsp_ready(rsp_ready0), .icb_rsp_err(1'b0),
    .busy(busy0), .done(done0), .err(err0), .core_hold(core_hold0)
  );

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) ncmd <= ncmd + 1;
    if (cmd_valid0) seen_cmd0 <= 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, {31'd0, cmd_valid}, 0);
    chk({tag, "_rrdy"}, {31'd0, rsp_ready}, 0);
    chk({tag, "_flags"}, {28'd0, busy, done, err, core_hold}, 32'h1);
    chk({tag, "_raddr"}, {22'd0, rom_addr}, 0);
    chk({tag, "_wdata"}, cmd_wdata, 0);
  endtask

  task automatic word(input int i, input int hold, input logic e);
    int cnt = 0;
    while (!cmd_valid && cnt < 20) begin
      cmd_ready = 0;
      @(negedge clk);
      cnt++;
    end
    chk($sformatf("w%0d_gap", i), cnt, 1);
    chk($sformatf("w%0d_addr", i), cmd_addr, 32'h8000_0000 + 4 * i);
    chk($sformatf("w%0d_data", i), cmd_wdata, 32'hB007_0000 + 3 * i);
    chk($sformatf("w%0d_hold", i), {30'd0, busy, core_hold}, 32'h3);
    for (int k = 0; k < hold; k++) begin
      cmd_ready = 0;
      @(negedge clk);
      chk($sformatf("w%0d_stall_vld", i), {31'd0, cmd_valid}, 1);
      chk($sformatf("w%0d_stall_addr", i), cmd_addr, 32'h8000_0000 + 4 * i);
      chk($sformatf("w%0d_stall_data", i), cmd_wdata, 32'hB007_0000 + 3 * i);
    end
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    chk($sformatf("w%0d_rsp_state", i), {30'd0, cmd_valid, rsp_ready}, 32'h1);
    rsp_valid = 1;
    rsp_err = e;
    @(negedge clk);
    rsp_valid = 0;
    rsp_err = 0;
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    chk("reset_const", {27'd0, cmd_read, cmd_wmask}, 32'h0F);
    rst = 0;
    rst0 = 0;
    @(negedge clk);
    rsp_valid = 1;
    rsp_err = 1;
    @(negedge clk);
    rsp_valid = 0;
    rsp_err = 0;
    @(negedge clk);
    chk("spurious_rsp", {28'd0, busy, done, err, core_hold}, 32'h1);
    chk("spurious_rsp_vld", {31'd0, cmd_valid}, 0);

    base = ncmd;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) start = 1;
      word(i, (i == 3) ? 5 : 0, 1'b0);
      start = 0;
    end
    chk("done_flags", {28'd0, busy, done, err, core_hold}, 32'h4);
    cmd_ready = 1;
    repeat (4) @(negedge clk);
    cmd_ready = 0;
    chk("done_sticky", {28'd0, busy, done, err, core_hold}, 32'h4);
    chk("done_ncmd", ncmd - base, 10);

    rst = 1;
    @(negedge clk);
    chk_reset("rst2");
    rst = 0;
    base = ncmd;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 5; i++) word(i, 0, i == 4);
    chk("err_flags", {28'd0, busy, done, err, core_hold}, 32'h3);
    cmd_ready = 1;
    repeat (5) @(negedge clk);
    cmd_ready = 0;
    chk("err_sticky", {28'd0, busy, done, err, core_hold}, 32'h3);
    chk("err_ncmd", ncmd - base, 5);

    rst = 1;
    @(negedge clk);
    rst = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    word(0, 0, 1'b0);
    word(1, 0, 1'b0);
    @(negedge clk);
    chk("abort_in_cmd", {31'd0, cmd_valid}, 1);
    chk("abort_addr", cmd_addr, 32'h8000_0008);
    rst = 1;
    @(negedge clk);
    chk_reset("abort");
    rst = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    word(0, 0, 1'b0);

    start0 = 1;
    @(negedge clk);
    start0 = 0;
    chk("len0_flags", {28'd0, busy0, done0, err0, core_hold0}, 32'h4);
    repeat (3) @(negedge clk);
    chk("len0_sticky", {28'd0, busy0, done0, err0, core_hold0}, 32'h4);
    chk("len0_nocmd", {31'd0, seen_cmd0}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
